byte_striping_ctrl: RTL and testbench

- Sequencing controller in front of the four byte-striping lanes, in the clk1Mhz domain.
- Accepts a packetized byte stream through a valid/ready handshake and assigns each byte to a lane in round-robin order over 1, 2 or 4 active lanes. Lane write strobes are one-hot.
- Pads an incomplete final stripe group with a fill byte so every packet ends lane-aligned.
- Honours per-lane full backpressure, and presents the lane index on a counter output compatible with the striping datapath.

---
 rtl/byte_striping_ctrl.sv | 101 ++++++++++
 tb/tb_byte_striping_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/byte_striping_ctrl.sv
// Round-robin byte striping controller: spreads a packetized byte stream over
// 1, 2 or 4 lanes with one-hot strobes and pads the final stripe group.
module byte_striping_ctrl #(
  parameter logic [7:0]  PAD_BYTE  = 8'hBC,
  parameter int unsigned NUM_LANES = 4
) (
  input  logic                 clk1Mhz,
  input  logic                 reset,
  input  logic [1:0]           cfg_lanes,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic [NUM_LANES-1:0] lane_full,
  output logic [7:0]           lane_data,
  output logic [NUM_LANES-1:0] lane_wr,
  output logic [1:0]           counter,
  output logic                 group_done,
  output logic                 pad_active,
  output logic                 busy
);

  localparam int unsigned LANE_W = 2;

  typedef enum logic [1:0] {IDLE, STRIPE, PAD} state_t;

  state_t               state, state_nxt;
  logic [LANE_W-1:0]    last_idx, last_idx_nxt;
  logic [LANE_W-1:0]    cfg_idx, eff_last, cnt_nxt;
  logic [7:0]           data_nxt;
  logic [NUM_LANES-1:0] wr_nxt;
  logic                 gd_nxt, at_end, in_ready_c;

  // Lane count is stored as the index of the last active lane (0, 1 or 3).
  assign cfg_idx = (cfg_lanes == 2'b00) ? LANE_W'(0) :
                   (cfg_lanes == 2'b01) ? LANE_W'(1) : LANE_W'(3);

  // The first byte of a packet already sees the lane count being latched.
  assign eff_last   = (state == IDLE) ? cfg_idx : last_idx;
  assign at_end     = (counter == eff_last);
  assign in_ready_c = (state != PAD) && !lane_full[counter];
  assign in_ready   = in_ready_c;

  always_ff @(posedge clk1Mhz or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = counter;
    last_idx_nxt = (state == IDLE) ? cfg_idx : last_idx;
    data_nxt     = lane_data;
    wr_nxt       = '0;
    gd_nxt       = 1'b0;
    unique case (state)
      IDLE, STRIPE: begin
        if (in_valid && in_ready_c) begin
          wr_nxt    = NUM_LANES'(1) << counter;
          data_nxt  = in_data;
          gd_nxt    = at_end;
          cnt_nxt   = at_end ? LANE_W'(0) : LANE_W'(counter + LANE_W'(1));
          if (in_last) state_nxt = at_end ? IDLE : PAD;
          else         state_nxt = STRIPE;
        end
      end
      PAD: begin
        if (!lane_full[counter]) begin
          wr_nxt   = NUM_LANES'(1) << counter;
          data_nxt = PAD_BYTE;
          gd_nxt   = at_end;
          cnt_nxt  = at_end ? LANE_W'(0) : LANE_W'(counter + LANE_W'(1));
          if (at_end) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registered lane interface and status flags.
  always_ff @(posedge clk1Mhz or negedge reset) begin
    if (!reset) begin
      counter    <= '0;
      last_idx   <= LANE_W'(3);
      lane_data  <= 8'h00;
      lane_wr    <= '0;
      group_done <= 1'b0;
      pad_active <= 1'b0;
      busy       <= 1'b0;
    end else begin
      counter    <= cnt_nxt;
      last_idx   <= last_idx_nxt;
      lane_data  <= data_nxt;
      lane_wr    <= wr_nxt;
      group_done <= gd_nxt;
      pad_active <= (state_nxt == PAD);
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_byte_striping_ctrl.sv
// Directed bench for byte_striping_ctrl: per-cycle vector table plus a
// hand-written reset-in-the-middle-of-a-packet sequence.
`timescale 1ns/1ps
module tb_byte_striping_ctrl;

  logic       clk1Mhz = 1'b0;
  logic       reset;
  logic [1:0] cfg_lanes;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_ready;
  logic [3:0] lane_full;
  logic [7:0] lane_data;
  logic [3:0] lane_wr;
  logic [1:0] counter;
  logic       group_done, pad_active, busy;

  int checks = 0;
  int errors = 0;

  byte_striping_ctrl dut (
    .clk1Mhz(clk1Mhz), .reset(reset), .cfg_lanes(cfg_lanes),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .lane_full(lane_full), .lane_data(lane_data),
    .lane_wr(lane_wr), .counter(counter), .group_done(group_done),
    .pad_active(pad_active), .busy(busy)
  );

  always #500 clk1Mhz = ~clk1Mhz;

  // One clock cycle: inputs, in_ready before the edge, registered outputs after.
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       l;
    logic [1:0] cfg;
    logic [3:0] full;
    logic       rdy;
    logic [3:0] wr;
    logic [7:0] od;
    logic       gd;
    logic [1:0] cnt;
    logic       pad;
    logic       bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic [1:0] cfg,
                              logic [3:0] full, logic rdy, logic [3:0] wr,
                              logic [7:0] od, logic gd, logic [1:0] cnt,
                              logic pad, logic bsy);
    vec_t r;
    r.v = v; r.d = d; r.l = l; r.cfg = cfg; r.full = full; r.rdy = rdy;
    r.wr = wr; r.od = od; r.gd = gd; r.cnt = cnt; r.pad = pad; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(vec_t t, string tag);
    @(negedge clk1Mhz);
    in_valid = t.v; in_data = t.d; in_last = t.l; cfg_lanes = t.cfg; lane_full = t.full;
    #1;
    chk({tag, " in_ready"}, 32'(in_ready), 32'(t.rdy));
    @(posedge clk1Mhz);
    #1;
    chk({tag, " lane_wr"}, 32'(lane_wr), 32'(t.wr));
    if (t.wr != 4'b0000) chk({tag, " lane_data"}, 32'(lane_data), 32'(t.od));
    chk({tag, " group_done"}, 32'(group_done), 32'(t.gd));
    chk({tag, " counter"}, 32'(counter), 32'(t.cnt));
    chk({tag, " pad_active"}, 32'(pad_active), 32'(t.pad));
    chk({tag, " busy"}, 32'(busy), 32'(t.bsy));
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " lane_wr"}, 32'(lane_wr), 32'h0);
    chk({tag, " lane_data"}, 32'(lane_data), 32'h0);
    chk({tag, " counter"}, 32'(counter), 32'h0);
    chk({tag, " group_done"}, 32'(group_done), 32'h0);
    chk({tag, " pad_active"}, 32'(pad_active), 32'h0);
    chk({tag, " busy"}, 32'(busy), 32'h0);
  endtask

  initial begin
    reset = 1'b0; cfg_lanes = 2'b10; in_valid = 1'b0; in_data = 8'h00;
    in_last = 1'b0; lane_full = 4'h0;

    // N=4, 8 bytes, no pad
    vecs.push_back(mk(1, 8'h01, 0, 2'b10, 4'h0, 1, 4'b0001, 8'h01, 0, 2'd1, 0, 1));
    vecs.push_back(mk(1, 8'h02, 0, 2'b10, 4'h0, 1, 4'b0010, 8'h02, 0, 2'd2, 0, 1));
    vecs.push_back(mk(1, 8'h03, 0, 2'b10, 4'h0, 1, 4'b0100, 8'h03, 0, 2'd3, 0, 1));
    vecs.push_back(mk(1, 8'h04, 0, 2'b10, 4'h0, 1, 4'b1000, 8'h04, 1, 2'd0, 0, 1));
    vecs.push_back(mk(1, 8'h05, 0, 2'b10, 4'h0, 1, 4'b0001, 8'h05, 0, 2'd1, 0, 1));
    vecs.push_back(mk(1, 8'h06, 0, 2'b10, 4'h0, 1, 4'b0010, 8'h06, 0, 2'd2, 0, 1));
    vecs.push_back(mk(1, 8'h07, 0, 2'b10, 4'h0, 1, 4'b0100, 8'h07, 0, 2'd3, 0, 1));
    vecs.push_back(mk(1, 8'h08, 1, 2'b10, 4'h0, 1, 4'b1000, 8'h08, 1, 2'd0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 2'b10, 4'h0, 1, 4'b0000, 8'h00, 0, 2'd0, 0, 0));
    // N=4, 5 bytes, three pad bytes; in_valid held high during PAD must be ignored
    vecs.push_back(mk(1, 8'hA0, 0, 2'b10, 4'h0, 1, 4'b0001, 8'hA0, 0, 2'd1, 0, 1));
    vecs.push_back(mk(1, 8'hA1, 0, 2'b10, 4'h0, 1, 4'b0010, 8'hA1, 0, 2'd2, 0, 1));
    vecs.push_back(mk(1, 8'hA2, 0, 2'b10, 4'h0, 1, 4'b0100, 8'hA2, 0, 2'd3, 0, 1));
    vecs.push_back(mk(1, 8'hA3, 0, 2'b10, 4'h0, 1, 4'b1000, 8'hA3, 1, 2'd0, 0, 1));
    vecs.push_back(mk(1, 8'hA4, 1, 2'b10, 4'h0, 1, 4'b0001, 8'hA4, 0, 2'd1, 1, 1));
    vecs.push_back(mk(1, 8'hFF, 0, 2'b10, 4'h0, 0, 4'b0010, 8'hBC, 0, 2'd2, 1, 1));
    vecs.push_back(mk(1, 8'hFF, 0, 2'b10, 4'h0, 0, 4'b0100, 8'hBC, 0, 2'd3, 1, 1));
    vecs.push_back(mk(1, 8'hFF, 0, 2'b10, 4'h0, 0, 4'b1000, 8'hBC, 1, 2'd0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 2'b10, 4'h0, 1, 4'b0000, 8'h00, 0, 2'd0, 0, 0));
    // N=2, 3 bytes, cfg changed to 4 lanes mid-packet, one pad byte
    vecs.push_back(mk(1, 8'h11, 0, 2'b01, 4'h0, 1, 4'b0001, 8'h11, 0, 2'd1, 0, 1));
    vecs.push_back(mk(1, 8'h12, 0, 2'b10, 4'h0, 1, 4'b0010, 8'h12, 1, 2'd0, 0, 1));
    vecs.push_back(mk(1, 8'h13, 1, 2'b10, 4'h0, 1, 4'b0001, 8'h13, 0, 2'd1, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 2'b10, 4'h0, 0, 4'b0010, 8'hBC, 1, 2'd0, 0, 0));
    // N=4 backpressure on lane 2 for 3 cycles; full on a non-current lane ignored
    vecs.push_back(mk(1, 8'h21, 0, 2'b10, 4'h0, 1, 4'b0001, 8'h21, 0, 2'd1, 0, 1));
    vecs.push_back(mk(1, 8'h22, 0, 2'b10, 4'h0, 1, 4'b0010, 8'h22, 0, 2'd2, 0, 1));
    vecs.push_back(mk(1, 8'h23, 0, 2'b10, 4'h4, 0, 4'b0000, 8'h00, 0, 2'd2, 0, 1));
    vecs.push_back(mk(1, 8'h23, 0, 2'b10, 4'h4, 0, 4'b0000, 8'h00, 0, 2'd2, 0, 1));
    vecs.push_back(mk(1, 8'h23, 0, 2'b10, 4'h4, 0, 4'b0000, 8'h00, 0, 2'd2, 0, 1));
    vecs.push_back(mk(1, 8'h23, 0, 2'b10, 4'h0, 1, 4'b0100, 8'h23, 0, 2'd3, 0, 1));
    vecs.push_back(mk(1, 8'h24, 1, 2'b10, 4'h2, 1, 4'b1000, 8'h24, 1, 2'd0, 0, 0));
    // N=4 pad write stalled by lane_full
    vecs.push_back(mk(1, 8'h31, 0, 2'b10, 4'h0, 1, 4'b0001, 8'h31, 0, 2'd1, 0, 1));
    vecs.push_back(mk(1, 8'h32, 1, 2'b10, 4'h0, 1, 4'b0010, 8'h32, 0, 2'd2, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 2'b10, 4'h4, 0, 4'b0000, 8'h00, 0, 2'd2, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 2'b10, 4'h0, 0, 4'b0100, 8'hBC, 0, 2'd3, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 2'b10, 4'h0, 0, 4'b1000, 8'hBC, 1, 2'd0, 0, 0));
    // N=1: every write on lane 0 with group_done, never PAD
    vecs.push_back(mk(1, 8'h41, 0, 2'b00, 4'h0, 1, 4'b0001, 8'h41, 1, 2'd0, 0, 1));
    vecs.push_back(mk(1, 8'h42, 0, 2'b00, 4'h0, 1, 4'b0001, 8'h42, 1, 2'd0, 0, 1));
    vecs.push_back(mk(1, 8'h43, 1, 2'b00, 4'h0, 1, 4'b0001, 8'h43, 1, 2'd0, 0, 0));
    vecs.push_back(mk(1, 8'h44, 1, 2'b00, 4'h0, 1, 4'b0001, 8'h44, 1, 2'd0, 0, 0));
    vecs.push_back(mk(0, 8'h00, 0, 2'b00, 4'h0, 1, 4'b0000, 8'h00, 0, 2'd0, 0, 0));

    // Power-on reset values
    repeat (2) @(posedge clk1Mhz);
    #1;
    chk_reset_vals("por");
    @(negedge clk1Mhz);
    reset = 1'b1;

    // Reset two bytes into an N=4 packet: no pad, outputs clear at once
    run(mk(1, 8'h51, 0, 2'b10, 4'h0, 1, 4'b0001, 8'h51, 0, 2'd1, 0, 1), "rst_pre0");
    run(mk(1, 8'h52, 0, 2'b10, 4'h0, 1, 4'b0010, 8'h52, 0, 2'd2, 0, 1), "rst_pre1");
    #100;
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    @(posedge clk1Mhz);
    #1;
    chk_reset_vals("rst_hold");
    @(negedge clk1Mhz);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      run(vecs[i], $sformatf("vec%0d", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
